// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing, IF/ID register,
// branch redirect / stall / flush handling, fetch-address fault trap and
// a saturating count of instructions delivered to decode.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal fetch; PC advances, redirects or holds
//   FAULT | bad fetch address seen; IF/ID shows a bubble until reset
module fetch_stage #(
    parameter int          N         = 64,
    parameter logic [31:0] NOP       = 32'h8b1f03ff,
    parameter int          ROM_WORDS = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_f,
    input  logic         flush_d,
    input  logic         pcsrc,
    input  logic [N-1:0] pc_branch,
    output logic [6:0]   imem_addr,
    input  logic [31:0]  imem_q,
    output logic [N-1:0] pc_f,
    output logic [31:0]  instr_d,
    output logic [N-1:0] pc_d,
    output logic         valid_d,
    output logic         fetch_fault,
    output logic [31:0]  fetch_count
);

    // First byte address past the end of the instruction ROM.
    localparam logic [N-1:0] PC_LIMIT = N'(4 * ROM_WORDS);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pcf_q, pcf_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [N-1:0] ifid_pc_q, ifid_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  count_q, count_d;

    logic [N-1:0] target;
    logic         target_bad;

    // Candidate next PC: branch beats stall, stall beats sequential.
    always_comb begin
        target = pcf_q + N'(4);
        if (pcsrc) begin
            target = pc_branch;
        end else if (stall_f) begin
            target = pcf_q;
        end
        target_bad = (target[1:0] != 2'b00) || (target >= PC_LIMIT);
    end

    // Next-state and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;

        unique case (state_q)
            RUN: begin
                if (target_bad) begin
                    // PC keeps the last good address for post-mortem.
                    state_d      = FAULT;
                    ifid_instr_d = NOP;
                    ifid_pc_d    = '0;
                    ifid_valid_d = 1'b0;
                end else begin
                    pcf_d = target;
                    if (pcsrc || flush_d) begin
                        ifid_instr_d = NOP;
                        ifid_pc_d    = '0;
                        ifid_valid_d = 1'b0;
                    end else if (!stall_f) begin
                        ifid_instr_d = imem_q;
                        ifid_pc_d    = pcf_q;
                        ifid_valid_d = 1'b1;
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_d = count_q + 32'd1;
                        end
                    end
                end
            end
            FAULT: begin
                ifid_instr_d = NOP;
                ifid_pc_d    = '0;
                ifid_valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC, IF/ID and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            pcf_q        <= '0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            count_q      <= count_d;
        end
    end

    assign imem_addr   = pcf_q[8:2];
    assign pc_f        = pcf_q;
    assign instr_d     = ifid_instr_q;
    assign pc_d        = ifid_pc_q;
    assign valid_d     = ifid_valid_q;
    assign fetch_fault = (state_q == FAULT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a ROM array driven combinationally from imem_addr,
// a reference model of the fetch rules updated each edge, a negedge compare
// process, and directed scenarios with literal expectations.
module tb_fetch_stage;

    localparam int          N         = 64;
    localparam logic [31:0] NOP       = 32'h8b1f03ff;
    localparam int          ROM_WORDS = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall_f = 1'b0;
    logic          flush_d = 1'b0;
    logic          pcsrc = 1'b0;
    logic [N-1:0]  pc_branch = '0;
    logic [6:0]    imem_addr;
    logic [31:0]   imem_q;
    logic [N-1:0]  pc_f;
    logic [31:0]   instr_d;
    logic [N-1:0]  pc_d;
    logic          valid_d;
    logic          fetch_fault;
    logic [31:0]   fetch_count;

    logic [31:0]   rom [ROM_WORDS];

    int checks = 0;
    int errors = 0;

    fetch_stage #(.N(N), .NOP(NOP), .ROM_WORDS(ROM_WORDS)) dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
        .pcsrc(pcsrc), .pc_branch(pc_branch), .imem_addr(imem_addr),
        .imem_q(imem_q), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
        .valid_d(valid_d), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    assign imem_q = rom[imem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what fetch must look like after each edge.
    logic [63:0] m_pc, m_pcd;
    logic [31:0] m_instr, m_count;
    logic        m_valid, m_fault, m_pcd_known;

    always @(posedge clk or negedge reset) begin
        logic [63:0] tgt;
        logic        bad;
        if (!reset) begin
            m_pc <= 0; m_pcd <= 0; m_instr <= NOP; m_count <= 0;
            m_valid <= 0; m_fault <= 0; m_pcd_known <= 1;
        end else if (m_fault) begin
            m_instr <= NOP; m_valid <= 0; m_pcd_known <= 0;
        end else begin
            if (pcsrc)        tgt = pc_branch;
            else if (stall_f) tgt = m_pc;
            else              tgt = m_pc + 4;
            bad = (tgt % 4 != 0) || (tgt > 4 * ROM_WORDS - 4);
            if (bad) begin
                m_fault <= 1; m_instr <= NOP; m_valid <= 0; m_pcd_known <= 0;
            end else begin
                m_pc <= tgt;
                if (pcsrc || flush_d) begin
                    m_instr <= NOP; m_pcd <= 0; m_valid <= 0; m_pcd_known <= 1;
                end else if (!stall_f) begin
                    m_instr <= rom[int'(m_pc / 4)];
                    m_pcd <= m_pc; m_valid <= 1; m_pcd_known <= 1;
                    if (m_count != 32'hFFFF_FFFF) m_count <= m_count + 1;
                end
            end
        end
    end

    // Compare DUT against model away from the active edge.
    always @(negedge clk) begin
        chk("pc_f", pc_f, m_pc);
        chk("imem_addr", 64'(imem_addr), m_pc / 4);
        chk("instr_d", 64'(instr_d), 64'(m_instr));
        chk("valid_d", 64'(valid_d), 64'(m_valid));
        chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
        chk("fetch_count", 64'(fetch_count), 64'(m_count));
        if (m_pcd_known) chk("pc_d", pc_d, m_pcd);
    end

    // Drive one cycle's inputs (called at a negedge), return at next negedge.
    task automatic step(input logic s, input logic f, input logic p, input logic [63:0] br);
        stall_f = s; flush_d = f; pcsrc = p; pc_branch = br;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; stall_f = 0; flush_d = 0; pcsrc = 0; pc_branch = 0;
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        logic [63:0] br;
        int r;
        rom[0] = 32'hf8000001;
        rom[1] = 32'hf8008002;
        rom[2] = 32'hf8010003;
        for (int i = 3; i < ROM_WORDS; i++) rom[i] = $urandom;

        @(negedge clk);
        chk("rst_pc_f", pc_f, 64'h0);
        chk("rst_instr", 64'(instr_d), 64'h8b1f03ff);
        chk("rst_valid", 64'(valid_d), 64'h0);
        @(negedge clk);
        reset = 1;

        // Free-run two edges.
        step(0, 0, 0, 0);
        chk("e1_instr", 64'(instr_d), 64'hf8000001);
        chk("e1_pc_d", pc_d, 64'h0);
        chk("e1_valid", 64'(valid_d), 64'h1);
        step(0, 0, 0, 0);
        chk("e2_instr", 64'(instr_d), 64'hf8008002);
        chk("e2_pc_d", pc_d, 64'h4);
        chk("e2_pc_f", pc_f, 64'h8);
        chk("e2_count", 64'(fetch_count), 64'd2);

        // Stall three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("stall_pc_f", pc_f, 64'h8);
            chk("stall_instr", 64'(instr_d), 64'hf8008002);
            chk("stall_pc_d", pc_d, 64'h4);
            chk("stall_count", 64'(fetch_count), 64'd2);
        end
        step(0, 0, 0, 0);
        chk("rel_instr", 64'(instr_d), 64'hf8010003);
        chk("rel_pc_d", pc_d, 64'h8);
        chk("rel_pc_f", pc_f, 64'hC);

        // Branch overrides stall.
        step(1, 0, 1, 64'h40);
        chk("br_pc_f", pc_f, 64'h40);
        chk("br_instr", 64'(instr_d), 64'h8b1f03ff);
        chk("br_valid", 64'(valid_d), 64'h0);
        step(0, 0, 0, 0);
        chk("br2_pc_d", pc_d, 64'h40);
        chk("br2_valid", 64'(valid_d), 64'h1);

        // Flush alone at pc 0x10.
        step(0, 0, 1, 64'h10);
        step(0, 1, 0, 0);
        chk("fl_pc_f", pc_f, 64'h14);
        chk("fl_instr", 64'(instr_d), 64'h8b1f03ff);
        chk("fl_valid", 64'(valid_d), 64'h0);
        chk("fl_count", 64'(fetch_count), 64'd4);

        // Randomised traffic with occasional bad targets and mid-cycle resets.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 85)      br = 64'($urandom_range(0, ROM_WORDS - 1)) * 4;
            else if (r < 93) br = 64'($urandom_range(0, ROM_WORDS - 1)) * 4 + 64'($urandom_range(1, 3));
            else             br = {32'($urandom), 32'($urandom)} | 64'h200;
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 15, br);
            if (m_fault && $urandom_range(0, 1) == 1) begin
                #2 reset = 0;
                @(negedge clk);
                reset = 1;
            end
        end

        // Misaligned branch target traps with the old PC kept.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'h42);
        chk("mis_fault", 64'(fetch_fault), 64'h1);
        chk("mis_pc_f", pc_f, 64'h8);
        chk("mis_valid", 64'(valid_d), 64'h0);
        step(1, 1, 1, 64'h40);
        chk("mis_hold_pc_f", pc_f, 64'h8);
        chk("mis_hold_count", 64'(fetch_count), 64'd2);

        // Sequential run off the end of the ROM.
        do_reset();
        for (int i = 0; i < 127; i++) step(0, 0, 0, 0);
        chk("end_pc_f", pc_f, 64'h1FC);
        chk("end_count", 64'(fetch_count), 64'd127);
        chk("end_nofault", 64'(fetch_fault), 64'h0);
        step(0, 0, 0, 0);
        chk("ovf_fault", 64'(fetch_fault), 64'h1);
        chk("ovf_pc_f", pc_f, 64'h1FC);
        chk("ovf_valid", 64'(valid_d), 64'h0);
        chk("ovf_count", 64'(fetch_count), 64'd127);
        step(0, 0, 1, 64'h0);
        chk("ovf_ign_pc_f", pc_f, 64'h1FC);
        chk("ovf_ign_fault", 64'(fetch_fault), 64'h1);

        // Asynchronous reset in the middle of a cycle while faulted.
        @(posedge clk);
        #3 reset = 0;
        #1;
        chk("ar_pc_f", pc_f, 64'h0);
        chk("ar_fault", 64'(fetch_fault), 64'h0);
        chk("ar_instr", 64'(instr_d), 64'h8b1f03ff);
        chk("ar_count", 64'(fetch_count), 64'h0);
        chk("ar_valid", 64'(valid_d), 64'h0);
        @(negedge clk);
        reset = 1;
        step(0, 0, 0, 0);
        chk("ar_rst_instr", 64'(instr_d), 64'hf8000001);
        chk("ar_rst_pc_f", pc_f, 64'h4);
        chk("ar_rst_fault", 64'(fetch_fault), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined LEGv8 datapath.
- Holds the PC and drives the 7-bit word address of the combinational instruction ROM (imem, 128 x 32).
- Registers the returned word and its PC into the IF/ID pipeline register.
- Handles stall, flush and branch redirect from the hazard/branch logic, detects out-of-range or misaligned fetch addresses, and keeps a retired-fetch counter.

Parameters:
- N, 64, width of the PC and of the branch-target datapath.
- NOP, 32'h8b1f03ff, encoding inserted into IF/ID on flush or fault (ADD XZR,XZR,XZR).
- ROM_WORDS, 128, imem depth in words. Valid byte range is 0 .. 4*ROM_WORDS-4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall_f  in  1  hold PC and IF/ID contents (load-use hazard).
- flush_d  in  1  replace the IF/ID contents with a bubble on the next edge.
- pcsrc  in  1  branch taken; redirect the PC to pc_branch.
- pc_branch  in  N  branch target byte address.
- imem_addr  out  7  word address to imem, equal to pc_f[8:2].
- imem_q  in  32  instruction word from imem, combinational in the same cycle.
- pc_f  out  N  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  N  IF/ID PC of instr_d.
- valid_d  out  1  instr_d is a real fetched instruction.
- fetch_fault  out  1  sticky; the fetch address went out of range or was misaligned.
- fetch_count  out  32  number of valid instructions loaded into IF/ID, saturating.

Behaviour:
- Reset (asynchronous, reset=0):
  - pc_f=0, instr_d=NOP, pc_d=0, valid_d=0, fetch_fault=0, fetch_count=0, state=RUN.
  - Deasserting reset mid-operation restarts fetch from PC 0 on the next edge.
- imem_addr = pc_f[8:2] at all times, purely combinational.
- Fetch latency: the word at pc_f appears on instr_d one edge later.
- States:
  - RUN: normal fetch.
  - FAULT: absorbing, left only by reset.
- RUN next-PC selection, in priority order:
  1. pcsrc=1: target is pc_branch. Overrides stall_f.
  2. stall_f=1: pc_f holds.
  3. Otherwise: pc_f+4, computed modulo 2^N.
- Target check:
  - A target is bad if target[1:0]!=0 or target[N-1:9]!=0, i.e. the byte address is at or above 4*ROM_WORDS.
  - A bad target causes: state goes to FAULT, pc_f keeps its old value, fetch_fault=1, instr_d=NOP, valid_d=0.
  - Sequential overflow is covered: pc_f=0x1FC with no stall and no branch faults on the next edge.
- RUN IF/ID update, in priority order:
  1. pcsrc=1 or flush_d=1: instr_d=NOP, pc_d=0, valid_d=0. The wrong-path word is discarded, and flush wins over stall.
  2. stall_f=1: instr_d, pc_d and valid_d all hold.
  3. Otherwise: instr_d=imem_q, pc_d=pc_f, valid_d=1.
- FAULT state:
  - pc_f, fetch_fault and fetch_count freeze.
  - instr_d=NOP, valid_d=0.
  - stall_f, flush_d and pcsrc are ignored.
- fetch_count:
  - Increments by 1 on every edge where rule 3 of the IF/ID update loads a valid instruction.
  - Saturates at 32'hFFFFFFFF.
- All state is updated on the rising clk edge only. There are no combinational paths from the inputs to any registered output. imem_addr depends only on pc_f.

Test Plan:
- Reset, then free-run with imem[0]=f8000001, imem[1]=f8008002 -> edge 1: instr_d=f8000001, pc_d=0, valid_d=1. Edge 2: instr_d=f8008002, pc_d=4, pc_f=8, fetch_count=2.
- Hold stall_f=1 for 3 cycles at pc_f=8 -> pc_f, instr_d, pc_d and fetch_count unchanged. Release -> fetch resumes at word 2 with no skipped word.
- pcsrc=1, pc_branch=0x40, with stall_f=1 and flush_d=0 in the same cycle -> next edge: pc_f=0x40, instr_d=8b1f03ff, valid_d=0. Following edge: pc_d=0x40, valid_d=1.
- flush_d=1 alone at pc_f=0x10 -> instr_d=NOP, valid_d=0, pc_f=0x14, fetch_count unchanged.
- pcsrc=1 with pc_branch=0x42, then a separate run free-running to pc_f=0x1FC -> fetch_fault=1, pc_f stays 0x1FC (or the old PC in the branch case), valid_d=0 thereafter, inputs ignored.
- Assert reset asynchronously mid-cycle while in FAULT -> outputs reach their reset values immediately, without waiting for a clock edge. After release, fetch restarts at PC 0 with fetch_fault=0.
